// File: rtl/common_defs_pkg.sv
// Shared definitions for the Path ORAM path sequencer.
// Holds the default tree geometry, widths derived from it, and the
// sequencer state encoding.
package common_defs_pkg;

  localparam int unsigned TREE_DEPTH   = 12;
  localparam int unsigned K            = 3;
  localparam int unsigned LVL_W        = $clog2(TREE_DEPTH + 1);
  localparam int unsigned NUM_NODES    = (2 ** (TREE_DEPTH + 1)) - 1;
  localparam int unsigned TUPLE_ADDR_W = $clog2(NUM_NODES * K);
  localparam int unsigned SLOT_W       = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WAIT_STASH,
    S_WRITE,
    S_DONE
  } oram_seq_state_t;

endpackage

// File: rtl/oram_bucket_addr.sv
// Combinational tuple address generator.
// Ports:
//   leaf  - leaf label selecting the root-to-leaf path
//   level - tree level, 0 = root
//   slot  - tuple slot within the bucket, 0..K-1
//   addr  - tuple address = node*K + slot,
//           node = (2^level - 1) + (leaf >> (TREE_DEPTH - level))
module oram_bucket_addr #(
  parameter int unsigned TREE_DEPTH = common_defs_pkg::TREE_DEPTH,
  parameter int unsigned K          = common_defs_pkg::K,
  localparam int unsigned LVL_W        = $clog2(TREE_DEPTH + 1),
  localparam int unsigned SLOT_W       = (K > 1) ? $clog2(K) : 1,
  localparam int unsigned TUPLE_ADDR_W = $clog2(((2 ** (TREE_DEPTH + 1)) - 1) * K)
) (
  input  logic [TREE_DEPTH-1:0]   leaf,
  input  logic [LVL_W-1:0]        level,
  input  logic [SLOT_W-1:0]       slot,
  output logic [TUPLE_ADDR_W-1:0] addr
);

  always_comb begin
    addr = TUPLE_ADDR_W'(
             (((32'd1 << level) - 32'd1) + (32'(leaf) >> (TREE_DEPTH - 32'(level)))) * K
             + 32'(slot));
  end

endmodule

// File: rtl/oram_path_sequencer.sv
// Path ORAM access sequencer: reads the root-to-leaf path of the requested
// leaf into the stash, waits for the stash, then writes the path back from
// leaf to root. Generates addresses and control only.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready/req_leaf - access request (accepted only in IDLE)
//   mem_re, mem_we, mem_addr - tuple memory strobes and address
//   load_valid, load_level   - read data valid for the stash (one cycle after mem_re)
//   stash_rdy                - stash has finished processing the loaded path
//   evict_req, evict_level, evict_ack - write-back handshake with the stash
//   busy, done               - not idle / one-cycle completion pulse
module oram_path_sequencer #(
  parameter int unsigned TREE_DEPTH = common_defs_pkg::TREE_DEPTH,
  parameter int unsigned K          = common_defs_pkg::K,
  localparam int unsigned LVL_W        = $clog2(TREE_DEPTH + 1),
  localparam int unsigned TUPLE_ADDR_W = $clog2(((2 ** (TREE_DEPTH + 1)) - 1) * K)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [TREE_DEPTH-1:0]   req_leaf,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [TUPLE_ADDR_W-1:0] mem_addr,
  output logic                    load_valid,
  output logic [LVL_W-1:0]        load_level,
  input  logic                    stash_rdy,
  output logic                    evict_req,
  output logic [LVL_W-1:0]        evict_level,
  input  logic                    evict_ack,
  output logic                    busy,
  output logic                    done
);

  import common_defs_pkg::*;

  localparam int unsigned SLOT_W = (K > 1) ? $clog2(K) : 1;

  oram_seq_state_t state_q, state_d;

  logic [TREE_DEPTH-1:0]   leaf_q;
  logic [LVL_W-1:0]        level_q;
  logic [SLOT_W-1:0]       slot_q;
  logic [TUPLE_ADDR_W-1:0] node_addr;
  logic                    last_slot;
  logic                    read_last;
  logic                    write_last;

  assign last_slot  = (slot_q == SLOT_W'(K - 1));
  assign read_last  = last_slot && (level_q == LVL_W'(TREE_DEPTH));
  assign write_last = last_slot && (level_q == '0);

  oram_bucket_addr #(
    .TREE_DEPTH(TREE_DEPTH),
    .K         (K)
  ) u_addr (
    .leaf (leaf_q),
    .level(level_q),
    .slot (slot_q),
    .addr (node_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (req_valid) state_d = S_READ;
      S_READ:       if (read_last) state_d = S_DRAIN;
      S_DRAIN:      state_d = S_WAIT_STASH;
      S_WAIT_STASH: if (stash_rdy) state_d = S_WRITE;
      S_WRITE:      if (evict_ack && write_last) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Strobes are masked by rst so nothing reaches memory during the reset
  // cycle even though the state register only clears on the edge.
  always_comb begin
    req_ready   = 1'b0;
    busy        = 1'b1;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    evict_req   = 1'b0;
    evict_level = '0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_READ: begin
        mem_re   = !rst;
        mem_addr = node_addr;
      end
      S_WRITE: begin
        evict_req   = !rst;
        evict_level = level_q;
        mem_we      = !rst && evict_ack;
        mem_addr    = node_addr;
      end
      S_DONE: done = !rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leaf_q     <= '0;
      level_q    <= '0;
      slot_q     <= '0;
      load_valid <= 1'b0;
      load_level <= '0;
    end else begin
      load_valid <= mem_re;
      load_level <= mem_re ? level_q : '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            leaf_q  <= req_leaf;
            level_q <= '0;
            slot_q  <= '0;
          end
        end
        S_READ: begin
          if (last_slot) begin
            slot_q <= '0;
            if (!read_last) level_q <= level_q + LVL_W'(1);
          end else begin
            slot_q <= slot_q + SLOT_W'(1);
          end
        end
        S_WAIT_STASH: begin
          if (stash_rdy) begin
            level_q <= LVL_W'(TREE_DEPTH);
            slot_q  <= '0;
          end
        end
        S_WRITE: begin
          if (evict_ack) begin
            if (last_slot) begin
              slot_q <= '0;
              // Hold level at 0 on the final ack; state leaves WRITE anyway.
              if (!write_last) level_q <= level_q - LVL_W'(1);
            end else begin
              slot_q <= slot_q + SLOT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oram_path_sequencer.sv
module tb_oram_path_sequencer;

  localparam int unsigned TD = 12;
  localparam int unsigned KK = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_leaf;
  logic        mem_re;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic        load_valid;
  logic [3:0]  load_level;
  logic        stash_rdy;
  logic        evict_req;
  logic [3:0]  evict_level;
  logic        evict_ack;
  logic        busy;
  logic        done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned rd_q[$];
  int unsigned ld_q[$];
  int unsigned wr_q[$];
  int unsigned wl_q[$];

  typedef struct {
    logic [11:0] leaf;
    int unsigned delay;
    bit          tog;
    bit          hold;
    int unsigned lat;
  } vec_t;

  vec_t vecs[6];

  oram_path_sequencer #(
    .TREE_DEPTH(TD),
    .K         (KK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_leaf   (req_leaf),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .load_valid (load_valid),
    .load_level (load_level),
    .stash_rdy  (stash_rdy),
    .evict_req  (evict_req),
    .evict_level(evict_level),
    .evict_ack  (evict_ack),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int unsigned model_addr(input int unsigned leaf, input int unsigned l,
                                             input int unsigned s);
    int unsigned node;
    node = ((1 << l) - 1) + (leaf >> (TD - l));
    return node * KK + s;
  endfunction

  // One access: push the expected path to the scoreboard, then drive the
  // stash side cycle by cycle and compare every memory transaction.
  // abort_c != 0 asserts rst in that cycle instead of completing.
  task automatic run_access(input logic [11:0] leaf, input int unsigned d, input bit tog,
                            input bit hold, input int unsigned abort_c, input int unsigned lat);
    int unsigned c;
    int unsigned wc;
    int unsigned e;
    bit          seen_done;
    bit          prev_re;
    bit          stalled;
    int unsigned stall_addr;
    rd_q.delete(); ld_q.delete(); wr_q.delete(); wl_q.delete();
    for (int unsigned l = 0; l <= TD; l++)
      for (int unsigned s = 0; s < KK; s++) begin
        rd_q.push_back(model_addr(leaf, l, s));
        ld_q.push_back(l);
      end
    for (int l = TD; l >= 0; l--)
      for (int unsigned s = 0; s < KK; s++) begin
        wr_q.push_back(model_addr(leaf, l, s));
        wl_q.push_back(l);
      end

    @(negedge clk);
    stash_rdy = (d == 0);
    evict_ack = 1'b0;
    req_valid = 1'b1;
    req_leaf  = leaf;
    #1;
    chk("req_ready_idle", req_ready, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk);

    c = 0; wc = 0; seen_done = 0; prev_re = 0; stalled = 0; stall_addr = 0;
    while (!seen_done && c < lat + 40) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        req_valid = hold;
        req_leaf  = ~leaf;
      end
      if (abort_c != 0 && c == abort_c) begin
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_cycle_re", mem_re, 0);
        chk("rst_cycle_we", mem_we, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("after_rst_ready", req_ready, 1);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_re", mem_re, 0);
        chk("after_rst_we", mem_we, 0);
        chk("after_rst_done", done, 0);
        chk("after_rst_load_valid", load_valid, 0);
        rst       = 1'b0;
        stash_rdy = 1'b0;
        evict_ack = 1'b0;
        rd_q.delete(); ld_q.delete(); wr_q.delete(); wl_q.delete();
        return;
      end
      stash_rdy = (d == 0) || (c >= 41 + d);
      if (evict_req) begin
        evict_ack = tog ? (wc % 2 == 0) : 1'b1;
        wc++;
      end else begin
        evict_ack = !tog;
      end
      #1;
      chk("busy_active", busy, 1);
      chk("req_ready_active", req_ready, 0);
      if (mem_re && mem_we) chk("re_we_exclusive", 1, 0);
      chk("load_valid_lag", load_valid, prev_re);
      if (load_valid) begin
        if (ld_q.size() == 0) chk("load_extra", 1, 0);
        else begin e = ld_q.pop_front(); chk("load_level", load_level, e); end
      end
      if (mem_re) begin
        if (rd_q.size() == 0) chk("read_extra", 1, 0);
        else begin e = rd_q.pop_front(); chk("read_addr", mem_addr, e); end
      end
      if (stalled) chk("stall_addr_hold", mem_addr, stall_addr);
      chk("we_is_req_and_ack", mem_we, evict_req && evict_ack);
      if (mem_we) begin
        if (wr_q.size() == 0) chk("write_extra", 1, 0);
        else begin
          e = wr_q.pop_front(); chk("write_addr", mem_addr, e);
          e = wl_q.pop_front(); chk("evict_level", evict_level, e);
        end
      end
      if (c >= 41 && c <= 41 + d) begin
        chk("wait_no_re", mem_re, 0);
        chk("wait_no_evict", evict_req, 0);
      end
      if (done) begin
        seen_done = 1;
        chk("latency", c, lat);
        chk("reads_left", rd_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);
        chk("loads_left", ld_q.size(), 0);
      end
      prev_re    = mem_re;
      stalled    = evict_req && !evict_ack;
      stall_addr = mem_addr;
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    stash_rdy = 1'b0;
    evict_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{leaf: 12'h000, delay: 0,  tog: 1'b0, hold: 1'b0, lat: 81};
    vecs[1] = '{leaf: 12'hFFF, delay: 0,  tog: 1'b0, hold: 1'b0, lat: 81};
    vecs[2] = '{leaf: 12'h5A3, delay: 10, tog: 1'b0, hold: 1'b0, lat: 91};
    vecs[3] = '{leaf: 12'h123, delay: 0,  tog: 1'b1, hold: 1'b0, lat: 119};
    vecs[4] = '{leaf: 12'h800, delay: 1,  tog: 1'b0, hold: 1'b1, lat: 82};
    vecs[5] = '{leaf: 12'h0F0, delay: 0,  tog: 1'b0, hold: 1'b1, lat: 81};

    rst = 1'b1; req_valid = 1'b0; req_leaf = '0; stash_rdy = 1'b0; evict_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_load_level", load_level, 0);
    chk("rst_evict_req", evict_req, 0);
    chk("rst_evict_level", evict_level, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_access(vecs[i].leaf, vecs[i].delay, vecs[i].tog, vecs[i].hold, 0, vecs[i].lat);
    req_valid = 1'b0;

    run_access(12'h03C, 0, 1'b0, 1'b0, 16, 81);
    run_access(12'h00A, 0, 1'b0, 1'b0, 0, 81);
    run_access(12'h0C3, 0, 1'b0, 1'b0, 60, 81);
    run_access(12'h00A, 3, 1'b1, 1'b0, 0, 122);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oram_path_sequencer.md
Name: oram_path_sequencer

Overview:
- Sequences one Path ORAM access over the bucket tree: reads every tuple on the root-to-leaf path into the stash, waits for the stash to finish remap/update, then writes the path back from leaf to root with tuples the stash selects.
- Sits between the ORAM front-end (request of a leaf label) and the bucket-tree memory plus stash.
- Generates addresses and control only; tuple data never passes through this block.

Parameters:
- TREE_DEPTH, common_defs_pkg::TREE_DEPTH (12), leaf-label width; tree has TREE_DEPTH+1 levels.
- K, common_defs_pkg::K (3), tuples per bucket.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE
- req_leaf  in  TREE_DEPTH  leaf label of the path
- mem_re  out  1  tuple read strobe, 1-cycle read latency
- mem_we  out  1  tuple write strobe
- mem_addr  out  TUPLE_ADDR_W  tuple address = node*K + slot
- load_valid  out  1  read data on memory bus is valid for the stash this cycle
- load_level  out  LVL_W  level of the tuple under load_valid
- stash_rdy  in  1  stash finished processing the loaded path
- evict_req  out  1  request a tuple for evict_level
- evict_level  out  LVL_W  level being written back
- evict_ack  in  1  stash drives the write data this cycle (may be combinational on evict_req)
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse when the access completes

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state IDLE. Reset mid-access returns to IDLE on the next edge. No mem_we or mem_re is issued in the reset cycle or after it.
- Node index at level l: (2^l - 1) + (leaf >> (TREE_DEPTH - l)), with l=0 as root. mem_addr = node*K + slot, slot 0..K-1.
- IDLE:
  - On req_valid (req_ready=1), latch req_leaf.
  - Set level=0, slot=0.
  - Go to READ.
- READ:
  - mem_re=1 every cycle at the current level/slot. Slot increments and wraps at K-1, then level increments.
  - After level=TREE_DEPTH, slot=K-1, go to DRAIN.
  - Takes exactly (TREE_DEPTH+1)*K cycles.
- load_valid/load_level: registered copies of mem_re and its level, so they lag mem_re by one cycle.
- DRAIN: one cycle covering the last load_valid, then go to WAIT_STASH.
- WAIT_STASH:
  - Hold until stash_rdy=1; this may take 0 extra cycles if stash_rdy is already high.
  - On exit, set level=TREE_DEPTH, slot=0, go to WRITE.
- WRITE:
  - evict_req=1, evict_level=level.
  - mem_we = evict_req & evict_ack; mem_addr is the current level/slot.
  - Position advances only on ack: slot wraps at K-1, then level decrements.
  - After level 0, slot K-1 is acked, go to DONE.
  - With continuous ack this takes (TREE_DEPTH+1)*K cycles; without ack it stalls indefinitely with address stable.
- DONE: done=1 for one cycle, then IDLE.
- req_valid outside IDLE is ignored (req_ready=0) and is not queued.
- mem_re and mem_we are never high in the same cycle.
- Minimum access latency, req accept to done: 2K(TREE_DEPTH+1)+3 cycles, which is 81 at defaults.

Decomposition:
- Add to common_defs_pkg:
  - LVL_W = $clog2(TREE_DEPTH+1)
  - NUM_NODES = 2^(TREE_DEPTH+1)-1
  - TUPLE_ADDR_W = $clog2(NUM_NODES*K), which is 15
  - SLOT_W = $clog2(K)
  - state enum typedef oram_seq_state_t
- One natural sub-module: oram_bucket_addr, combinational leaf/level/slot -> mem_addr.

Test Plan:
- Leaf 0, stash_rdy=1, evict_ack=1:
  - mem_re addresses 0,1,2 (root), then 3,4,5, ..., last 12285..12287.
  - Writes in order 12285..12287, ..., 0..2.
  - done exactly 81 cycles after accept.
- Leaf 0xFFF:
  - Level-1 addresses 6..8; level-12 addresses 24570..24572.
  - load_level runs 0..12, lagging mem_re by one cycle.
- stash_rdy held low 10 cycles after DRAIN:
  - No mem activity, busy=1.
  - Write starts the cycle after stash_rdy rises; done at cycle 91.
- evict_ack toggled every other cycle in WRITE:
  - mem_we only on ack cycles; mem_addr holds during stalls.
  - 39 total writes, no skipped or duplicated address.
- rst asserted mid-READ (level 5), then mid-WRITE:
  - Next cycle IDLE, req_ready=1, mem_re/mem_we/done=0.
  - A following request with leaf 0x00A runs a full correct access.
- req_valid held high throughout:
  - A second access is accepted only the cycle after done.
  - Concurrent requests are ignored while busy.
